// File: rtl/layer_compositor_if.sv
// Pixel/palette bus of the layer compositor.
// The master drives pixels and palette writes; the slave (compositor) returns the composed pixel.
interface layer_compositor_if #(
  parameter int NUM_LAYERS   = 12,
  parameter int IDX_W        = 4,
  parameter int NUM_PALETTES = 4
);
  localparam int PSEL_W  = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
  localparam int LAYER_W = $clog2(NUM_LAYERS + 1);

  logic                           i_valid;
  logic [NUM_LAYERS*IDX_W-1:0]    i_layer_idx;
  logic [NUM_LAYERS-1:0]          i_layer_en;
  logic [NUM_LAYERS*PSEL_W-1:0]   i_layer_pal;
  logic [NUM_LAYERS-1:0]          i_layer_flash;
  logic [IDX_W-1:0]               i_bg_idx;
  logic [PSEL_W-1:0]              i_bg_pal;
  logic                           i_frame_start;
  logic                           i_pal_we;
  logic [PSEL_W+IDX_W-1:0]        i_pal_waddr;
  logic [23:0]                    i_pal_wdata;
  logic                           o_valid;
  logic [7:0]                     o_vga_r;
  logic [7:0]                     o_vga_g;
  logic [7:0]                     o_vga_b;
  logic [LAYER_W-1:0]             o_layer;

  modport master (
    output i_valid, i_layer_idx, i_layer_en, i_layer_pal, i_layer_flash,
           i_bg_idx, i_bg_pal, i_frame_start, i_pal_we, i_pal_waddr, i_pal_wdata,
    input  o_valid, o_vga_r, o_vga_g, o_vga_b, o_layer
  );

  modport slave (
    input  i_valid, i_layer_idx, i_layer_en, i_layer_pal, i_layer_flash,
           i_bg_idx, i_bg_pal, i_frame_start, i_pal_we, i_pal_waddr, i_pal_wdata,
    output o_valid, o_vga_r, o_vga_g, o_vga_b, o_layer
  );
endinterface

// File: rtl/layer_compositor.sv
// Two-stage priority compositor of NUM_LAYERS indexed sprite layers over an opaque background.
// Optional hit-flash blinking is enabled by defining LAYER_COMPOSITOR_FLASH_EN.
module layer_compositor #(
  parameter int NUM_LAYERS   = 12,
  parameter int IDX_W        = 4,
  parameter int NUM_PALETTES = 4,
  parameter int MASK_IDX     = 0,
  parameter int FLASH_FRAMES = 8
) (
  input logic               clk,
  input logic               rst,
  layer_compositor_if.slave bus
);
  localparam int PSEL_W  = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
  localparam int LAYER_W = $clog2(NUM_LAYERS + 1);
  localparam int ADDR_W  = PSEL_W + IDX_W;

  function automatic logic [PSEL_W-1:0] bank_clamp(input logic [PSEL_W-1:0] bank);
    return (32'(bank) < NUM_PALETTES) ? bank : '0;
  endfunction

  logic                         r_s1_valid;
  logic [NUM_LAYERS*IDX_W-1:0]  r_s1_idx;
  logic [NUM_LAYERS-1:0]        r_s1_en;
  logic [NUM_LAYERS*PSEL_W-1:0] r_s1_pal;
  logic [IDX_W-1:0]             r_s1_bg_idx;
  logic [PSEL_W-1:0]            r_s1_bg_pal;
  logic [NUM_LAYERS-1:0]        w_s1_flash;

  logic                         r_out_valid;
  logic [23:0]                  r_out_rgb;
  logic [LAYER_W-1:0]           r_out_layer;

  logic [LAYER_W-1:0]           w_win_layer;
  logic [IDX_W-1:0]             w_win_idx;
  logic [PSEL_W-1:0]            w_win_pal;
  logic [ADDR_W-1:0]            w_rd_addr;
  logic [PSEL_W-1:0]            w_wr_bank;
  logic                         w_wr_en;

  logic [23:0] r_pal_mem [NUM_PALETTES * (2**IDX_W)];

  // NOTE: the palette RAM has no reset so it maps onto plain RAM; software loads it before use.
  assign w_wr_bank = bus.i_pal_waddr[IDX_W +: PSEL_W];
  assign w_wr_en   = bus.i_pal_we && (32'(w_wr_bank) < NUM_PALETTES);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_pal_mem[bus.i_pal_waddr] <= bus.i_pal_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_en     <= '0;
      r_s1_pal    <= '0;
      r_s1_bg_idx <= '0;
      r_s1_bg_pal <= '0;
    end else begin
      r_s1_valid  <= bus.i_valid;
      r_s1_idx    <= bus.i_layer_idx;
      r_s1_en     <= bus.i_layer_en;
      r_s1_pal    <= bus.i_layer_pal;
      r_s1_bg_idx <= bus.i_bg_idx;
      r_s1_bg_pal <= bus.i_bg_pal;
    end
  end

`ifdef LAYER_COMPOSITOR_FLASH_EN
  localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [FC_W-1:0]       r_frame_cnt;
  logic                  r_flash_phase;
  logic [NUM_LAYERS-1:0] r_s1_flash;

  // The stage-1 mask samples the phase before this edge's frame_start update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_flash_phase <= 1'b0;
      r_s1_flash    <= '0;
    end else begin
      if (bus.i_frame_start) begin
        if (r_frame_cnt == FC_W'(FLASH_FRAMES - 1)) begin
          r_frame_cnt   <= '0;
          r_flash_phase <= ~r_flash_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
      r_s1_flash <= r_flash_phase ? bus.i_layer_flash : '0;
    end
  end

  assign w_s1_flash = r_s1_flash;
`else
  logic w_unused_flash;
  assign w_unused_flash = ^{bus.i_layer_flash, bus.i_frame_start};
  assign w_s1_flash     = '0;
`endif

  // Descending scan so the lowest-numbered opaque layer is the last to overwrite the winner.
  always_comb begin
    w_win_layer = LAYER_W'(NUM_LAYERS);
    w_win_idx   = r_s1_bg_idx;
    w_win_pal   = bank_clamp(r_s1_bg_pal);
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (r_s1_en[k] && (r_s1_idx[k*IDX_W +: IDX_W] != IDX_W'(MASK_IDX)) && !w_s1_flash[k]) begin
        w_win_layer = LAYER_W'(k);
        w_win_idx   = r_s1_idx[k*IDX_W +: IDX_W];
        w_win_pal   = bank_clamp(r_s1_pal[k*PSEL_W +: PSEL_W]);
      end
    end
  end

  assign w_rd_addr = {w_win_pal, w_win_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_rgb   <= '0;
      r_out_layer <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_rgb   <= r_pal_mem[w_rd_addr];
        r_out_layer <= w_win_layer;
      end
    end
  end

  assign bus.o_valid = r_out_valid;
  assign bus.o_vga_r = r_out_rgb[23:16];
  assign bus.o_vga_g = r_out_rgb[15:8];
  assign bus.o_vga_b = r_out_rgb[7:0];
  assign bus.o_layer = r_out_layer;
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised, pipelined successor to the fixed-layer pixel colour mapper.
- Merges NUM_LAYERS indexed sprite layers (players, bullets, HUD) and one opaque background layer into a single 24-bit VGA pixel.
- Palettes live in one runtime-writable palette RAM with NUM_PALETTES banks. Each layer picks its own bank per pixel.
- Sits between the per-sprite ROM address/data logic and the VGA output registers. Latency is 2 cycles and it accepts one pixel per cycle.

Parameters:
- NUM_LAYERS, 12, number of sprite layers; layer 0 has the highest priority.
- IDX_W, 4, colour-index width; each bank holds 2**IDX_W entries.
- NUM_PALETTES, 4, number of palette banks; PSEL_W = max(1, clog2(NUM_PALETTES)).
- MASK_IDX, 0, colour index treated as transparent on sprite layers.
- FLASH_FRAMES, 8, number of frames per flash half-period (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  the pixel on the inputs is valid this cycle.
- layer_idx  in  NUM_LAYERS*IDX_W  colour index per layer; layer k occupies bits [k*IDX_W +: IDX_W].
- layer_en  in  NUM_LAYERS  layer k covers the current pixel (replaces the is_* flags).
- layer_pal  in  NUM_LAYERS*PSEL_W  palette bank per layer.
- layer_flash  in  NUM_LAYERS  layer k is in hit-flash mode.
- bg_idx  in  IDX_W  background colour index.
- bg_pal  in  PSEL_W  background palette bank.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  PSEL_W+IDX_W  write address as {bank, index}.
- pal_wdata  in  24  RGB888 value to write.
- out_valid  out  1  output pixel is valid.
- VGA_R  out  8  red.
- VGA_G  out  8  green.
- VGA_B  out  8  blue.
- out_layer  out  clog2(NUM_LAYERS+1)  winning layer number; NUM_LAYERS means background.

Behaviour:
- Reset (asynchronous): out_valid=0, VGA_R/G/B=0, out_layer=0, all stage registers cleared, flash counter=0, flash phase=0. Palette RAM contents are not affected by Reset and are undefined until written.
- Stage 1 (edge after input): register in_valid, layer_idx, layer_en, layer_pal, bg_idx, bg_pal and the effective flash mask.
- Layer k is opaque when layer_en[k]=1 and layer_idx[k]!=MASK_IDX and it is not flash-suppressed.
  - Transparency is decided by index, not by colour compare.
  - The winner is the lowest-numbered opaque layer; if none is opaque, the background wins. Background is always opaque, including when bg_idx==MASK_IDX.
- Stage 2: read the palette at {pal_sel, idx} of the winner and register the colour, out_layer and out_valid.
- Latency: in_valid high at cycle t gives out_valid high at cycle t+2. Throughput is 1 pixel/cycle with no stall. in_valid=0 bubbles propagate as out_valid=0.
- While out_valid=0, VGA_R/G/B and out_layer hold their last values.
- Palette writes commit on the clock edge.
  - A write in cycle t is visible to pixels accepted in cycle t or later.
  - A write in cycle t is not visible to pixels accepted in cycle t-1 or earlier.
- Bank bound: if a layer_pal or bg_pal value is >= NUM_PALETTES, that layer uses bank 0. pal_we with a bank >= NUM_PALETTES is ignored.
- Reset mid-stream: in-flight pixels are discarded and out_valid=0 from the reset assertion.

Optional Feature:
- Macro: LAYER_COMPOSITOR_FLASH_EN.
- Defined:
  - A frame counter increments on each frame_start and wraps from FLASH_FRAMES-1 to 0.
  - Each wrap toggles the flash phase.
  - While phase=1, layers with layer_flash=1 are treated as transparent. Phase is sampled in stage 1.
  - frame_start and in_valid in the same cycle: the pixel uses the pre-update phase.
- Undefined: no counter exists, layer_flash is ignored, and there is no extra state.

Test Plan:
- Assert Reset mid-operation -> out_valid=0 and VGA_R/G/B=0 immediately (asynchronous, before any edge); remains so 2 cycles after release with in_valid=0.
- Write bank1 idx3 = 24'hF83800; layer 2 en, idx=3, pal=1, in_valid at cycle t -> at t+2: VGA=F8/38/00, out_layer=2, out_valid=1.
- Layers 0 and 5 both opaque (different colours) -> layer 0 colour, out_layer=0. Next pixel has layer 0 idx=MASK_IDX -> layer 5 colour, out_layer=5.
- All layers disabled, bg_idx=0, bg bank0 idx0 = 24'h005000 -> VGA=00/50/00, out_layer=NUM_LAYERS.
- 10 back-to-back pixels with a palette write in the same cycle as pixel 4 -> 10 consecutive out_valid cycles; pixels 0-3 show the old colour, pixels 4-9 the new one.
- With the macro, FLASH_FRAMES=2, layer 0 flash, 2 frame_start pulses -> layer 0 is suppressed and the next layer/background shows; 2 more pulses -> layer 0 is visible again.
